// File: rtl/hazard_stall_ctrl.sv
// ID/EX control-pipeline register with hazard bubble insertion and branch flush.
// Optional build macro HAZARD_STALL_STATS_EN adds a saturating hazard-bubble counter port.
module hazard_stall_ctrl #(
    parameter int                CTRL_W    = 7,
    parameter int                STALL_CYC = 1,
    parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}}
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              hazard_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              valid_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              stall_busy_o
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    localparam int CNT_W = $clog2(STALL_CYC + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CTRL_W-1:0]   r_ctrl;
    logic                r_valid;
    logic                r_busy;

    logic                w_stall_now;
    logic [CTRL_W-1:0]   w_bubble_ctrl;

    // Bits set in KILL_MASK are forced low in a bubble; the rest follow ID.
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_bubble
            assign w_bubble_ctrl[gi] = KILL_MASK[gi] ? 1'b0 : ctrl_i[gi];
        end
    endgenerate

    assign w_stall_now  = ~flush_i & (((r_state == S_IDLE) & hazard_i) | (r_state == S_STALL));

    // Gated by reset so the front end keeps running while held in reset.
    assign pc_write_o   = ~(w_stall_now & rst_n_i);
    assign ifid_write_o = ~(w_stall_now & rst_n_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ctrl  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else if (flush_i) begin
            r_ctrl  <= w_bubble_ctrl;
            r_valid <= 1'b0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (hazard_i) begin
                        r_ctrl  <= w_bubble_ctrl;
                        r_valid <= 1'b0;
                        if (STALL_CYC > 1) begin
                            r_cnt   <= CNT_W'(STALL_CYC - 1);
                            r_state <= S_STALL;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_ctrl  <= ctrl_i;
                        r_valid <= valid_i;
                    end
                end
                S_STALL: begin
                    // hazard_i is ignored here; the count alone ends the stall.
                    r_ctrl  <= w_bubble_ctrl;
                    r_valid <= 1'b0;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_o       = r_ctrl;
    assign valid_o      = r_valid;
    assign stall_busy_o = r_busy;

`ifdef HAZARD_STALL_STATS_EN
    logic [15:0] r_stall_cnt;

    // Every edge that holds the front end for a hazard emits one counted bubble.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall_now && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three parameterisations driven in parallel, hand tables plus random
// stimulus checked against a hold-counter reference model.
module tb_hazard_stall_ctrl;

    localparam int W = 7;
    localparam int SC0 = 1;
    localparam int SC1 = 3;
    localparam int SC2 = 2;
    localparam logic [W-1:0] KM2 = 7'h3C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hazard = 1'b0;
    logic flush = 1'b0;
    logic valid = 1'b0;
    logic [W-1:0] ctrl = '0;

    logic [2:0][W-1:0] ctrl_o;
    logic [2:0]        valid_o;
    logic [2:0]        pw_o;
    logic [2:0]        iw_o;
    logic [2:0]        busy_o;
`ifdef HAZARD_STALL_STATS_EN
    logic [2:0][15:0]  scnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CTRL_W(W), .STALL_CYC(SC0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .hazard_i(hazard), .flush_i(flush), .valid_i(valid),
        .ctrl_i(ctrl), .ctrl_o(ctrl_o[0]), .valid_o(valid_o[0]), .pc_write_o(pw_o[0]),
        .ifid_write_o(iw_o[0]), .stall_busy_o(busy_o[0])
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cnt_o(scnt_o[0])
`endif
    );

    hazard_stall_ctrl #(.CTRL_W(W), .STALL_CYC(SC1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .hazard_i(hazard), .flush_i(flush), .valid_i(valid),
        .ctrl_i(ctrl), .ctrl_o(ctrl_o[1]), .valid_o(valid_o[1]), .pc_write_o(pw_o[1]),
        .ifid_write_o(iw_o[1]), .stall_busy_o(busy_o[1])
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cnt_o(scnt_o[1])
`endif
    );

    hazard_stall_ctrl #(.CTRL_W(W), .STALL_CYC(SC2), .KILL_MASK(KM2)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .hazard_i(hazard), .flush_i(flush), .valid_i(valid),
        .ctrl_i(ctrl), .ctrl_o(ctrl_o[2]), .valid_o(valid_o[2]), .pc_write_o(pw_o[2]),
        .ifid_write_o(iw_o[2]), .stall_busy_o(busy_o[2])
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cnt_o(scnt_o[2])
`endif
    );

    // Reference model: remaining held cycles per hazard, plus the expected register contents.
    int           m_sc[3];
    logic [W-1:0] m_km[3];
    int           m_hold[3];
    logic [W-1:0] m_ctrl[3];
    logic         m_valid[3];
    int           m_stats[3];

    function automatic bit m_stall(int i);
        return !flush && (m_hold[i] > 0 || hazard);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_hold[i] = 0; m_ctrl[i] = '0; m_valid[i] = 1'b0; m_stats[i] = 0;
        end
    endtask

    task automatic m_edge();
        for (int i = 0; i < 3; i++) begin
            if (flush) begin
                m_ctrl[i] = ctrl & ~m_km[i]; m_valid[i] = 1'b0; m_hold[i] = 0;
            end else if (m_hold[i] > 0 || hazard) begin
                m_ctrl[i] = ctrl & ~m_km[i]; m_valid[i] = 1'b0;
                m_hold[i] = (m_hold[i] > 0) ? m_hold[i] - 1 : m_sc[i] - 1;
                if (m_stats[i] < 65535) m_stats[i]++;
            end else begin
                m_ctrl[i] = ctrl; m_valid[i] = valid;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive, check combinational outputs, clock, check registers.
    task automatic step(input logic h, input logic f, input logic v, input logic [W-1:0] c,
                        output logic [2:0] pw_seen);
        hazard = h; flush = f; valid = v; ctrl = c;
        #1;
        pw_seen = pw_o;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pc_write[%0d]", i), {31'd0, pw_o[i]}, {31'd0, !m_stall(i)});
            chk($sformatf("ifid_write[%0d]", i), {31'd0, iw_o[i]}, {31'd0, !m_stall(i)});
        end
        @(posedge clk);
        m_edge();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ctrl_o[%0d]", i), {25'd0, ctrl_o[i]}, {25'd0, m_ctrl[i]});
            chk($sformatf("valid_o[%0d]", i), {31'd0, valid_o[i]}, {31'd0, m_valid[i]});
            chk($sformatf("busy[%0d]", i), {31'd0, busy_o[i]}, {31'd0, (m_hold[i] > 0)});
`ifdef HAZARD_STALL_STATS_EN
            chk($sformatf("stall_cnt[%0d]", i), {16'd0, scnt_o[i]}, m_stats[i]);
`endif
        end
        $display("step h=%0b f=%0b v=%0b c=%02h -> ctrl=%02h/%02h/%02h valid=%03b busy=%03b",
                 h, f, v, c, ctrl_o[0], ctrl_o[1], ctrl_o[2], valid_o, busy_o);
        @(negedge clk);
    endtask

    // Asserts reset in the middle of the low phase and checks outputs before any edge.
    task automatic do_reset();
        hazard = 1'b1; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ctrl[%0d]", i), {25'd0, ctrl_o[i]}, 32'd0);
            chk($sformatf("rst_valid[%0d]", i), {31'd0, valid_o[i]}, 32'd0);
            chk($sformatf("rst_pc_write[%0d]", i), {31'd0, pw_o[i]}, 32'd1);
            chk($sformatf("rst_ifid_write[%0d]", i), {31'd0, iw_o[i]}, 32'd1);
            chk($sformatf("rst_busy[%0d]", i), {31'd0, busy_o[i]}, 32'd0);
`ifdef HAZARD_STALL_STATS_EN
            chk($sformatf("rst_stall_cnt[%0d]", i), {16'd0, scnt_o[i]}, 32'd0);
`endif
        end
        m_reset();
        $display("reset asserted mid-cycle, outputs checked");
        @(negedge clk);
        hazard = 1'b0;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic         h;
        logic         f;
        logic         v;
        logic [W-1:0] c;
        logic         pw;
        logic [W-1:0] e_ctrl;
        logic         e_valid;
        logic         e_busy;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [2:0] pw;
        logic [15:0] s_before;
        m_sc[0] = SC0; m_sc[1] = SC1; m_sc[2] = SC2;
        m_km[0] = 7'h7F; m_km[1] = 7'h7F; m_km[2] = KM2;
        m_reset();
        s_before = '0;

        // Expectations for the STALL_CYC=3 instance.
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 7'h12, 1'b1, 7'h12, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 7'h5B, 1'b0, 7'h00, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 7'h5B, 1'b0, 7'h00, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 7'h5B, 1'b0, 7'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 7'h5B, 1'b1, 7'h5B, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 7'h21, 1'b0, 7'h00, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 7'h21, 1'b1, 7'h00, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 7'h33, 1'b1, 7'h33, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 7'h44, 1'b1, 7'h00, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 7'h6A, 1'b1, 7'h6A, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 7'h11, 1'b0, 7'h00, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 7'h11, 1'b0, 7'h00, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 7'h11, 1'b0, 7'h00, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 7'h11, 1'b0, 7'h00, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 7'h11, 1'b0, 7'h00, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 7'h11, 1'b0, 7'h00, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 7'h7F, 1'b1, 7'h7F, 1'b1, 1'b0};

        @(negedge clk);
        @(negedge clk);
        do_reset();

        for (int r = 0; r < 17; r++) begin
            step(tbl[r].h, tbl[r].f, tbl[r].v, tbl[r].c, pw);
            chk($sformatf("tbl%0d_pc_write", r), {31'd0, pw[1]}, {31'd0, tbl[r].pw});
            chk($sformatf("tbl%0d_ctrl", r), {25'd0, ctrl_o[1]}, {25'd0, tbl[r].e_ctrl});
            chk($sformatf("tbl%0d_valid", r), {31'd0, valid_o[1]}, {31'd0, tbl[r].e_valid});
            chk($sformatf("tbl%0d_busy", r), {31'd0, busy_o[1]}, {31'd0, tbl[r].e_busy});
        end

        // Single-cycle stall instance: one bubble then the held instruction.
        step(1'b1, 1'b0, 1'b1, 7'h5B, pw);
        chk("sc1_pc_write", {31'd0, pw[0]}, 32'd0);
        chk("sc1_bubble_ctrl", {25'd0, ctrl_o[0]}, 32'd0);
        chk("sc1_bubble_valid", {31'd0, valid_o[0]}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 7'h5B, pw);
        chk("sc1_pass_ctrl", {25'd0, ctrl_o[0]}, 32'h5B);
        chk("sc1_pass_pc_write", {31'd0, pw[0]}, 32'd1);

        // Partial kill mask and two hazards on the STALL_CYC=2 instance.
`ifdef HAZARD_STALL_STATS_EN
        s_before = scnt_o[2];
`endif
        step(1'b1, 1'b0, 1'b1, 7'h7F, pw);
        chk("mask_bubble1", {25'd0, ctrl_o[2]}, 32'h43);
        step(1'b0, 1'b0, 1'b1, 7'h7F, pw);
        chk("mask_bubble2", {25'd0, ctrl_o[2]}, 32'h43);
        step(1'b1, 1'b0, 1'b1, 7'h7F, pw);
        chk("mask_bubble3", {25'd0, ctrl_o[2]}, 32'h43);
        step(1'b0, 1'b0, 1'b1, 7'h7F, pw);
        chk("mask_bubble4", {25'd0, ctrl_o[2]}, 32'h43);
`ifdef HAZARD_STALL_STATS_EN
        chk("stats_two_hazards", {16'd0, scnt_o[2] - s_before}, 32'd4);
`endif
        step(1'b0, 1'b0, 1'b1, 7'h7F, pw);
        chk("mask_pass", {25'd0, ctrl_o[2]}, 32'h7F);

        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 80), W'($urandom), pw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
